// File: rtl/pc_sequencer.sv
// Registered program counter with stall, issue counter and next-PC selection for B/BL, CBZ/CBNZ and BR.
// Optional return-address stack is built only when the macro PC_RAS_EN is defined.
module pc_sequencer #(
    parameter int               ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               RAS_DEPTH = 4,
    parameter int               CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              BranchNZ,
    input  logic              ALUZero,
    input  logic              Uncondbranch,
    input  logic              Link,
    input  logic              Return,
    input  logic [ADDR_W-1:0] RegTarget,
    input  logic [63:0]       SignExtImm64,
    output logic [ADDR_W-1:0] CurrentPC,
    output logic [ADDR_W-1:0] NextPC,
    output logic              Taken,
    output logic [CNT_W-1:0]  IssueCount,
    output logic              RasEmpty
);

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_issue_cnt;

    logic [65:0]       w_imm_x4;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_ret_tgt;
    logic              w_cond_taken;
    logic              w_unused;
    logic              w_unused_cfg;

    // Word offset to byte offset; bits above ADDR_W are simply dropped.
    assign w_imm_x4     = {SignExtImm64, 2'b00};
    assign w_off        = w_imm_x4[ADDR_W-1:0];
    assign w_pc_plus4   = r_pc + ADDR_W'(4);
    assign w_branch_tgt = r_pc + w_off;
    assign w_cond_taken = Branch & (ALUZero ^ BranchNZ);
    assign w_unused     = ^{w_imm_x4, w_unused_cfg};

    always_comb begin
        NextPC = w_pc_plus4;
        Taken  = 1'b0;
        if (Return) begin
            NextPC = w_ret_tgt;
            Taken  = 1'b1;
        end else if (Uncondbranch || w_cond_taken) begin
            NextPC = w_branch_tgt;
            Taken  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc        <= RESET_PC;
            r_issue_cnt <= '0;
        end else if (!Stall) begin
            r_pc        <= NextPC;
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
    end

    assign CurrentPC  = r_pc;
    assign IssueCount = r_issue_cnt;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ras_ptr;
    logic [PTR_W:0]    r_ras_cnt;

    logic [PTR_W-1:0]  w_ras_top_idx;
    logic [PTR_W-1:0]  w_ras_wr_idx;
    logic              w_ras_empty;
    logic              w_ras_replace;
    logic              w_ras_push;
    logic              w_ras_pop;
    logic              w_ras_active;

    // r_ras_ptr is the next free slot; the top lives one below it, wrapping.
    assign w_ras_top_idx = r_ras_ptr - PTR_W'(1);
    assign w_ras_empty   = (r_ras_cnt == '0);
    assign w_ret_tgt     = w_ras_empty ? RegTarget : r_ras[w_ras_top_idx];
    assign w_ras_active  = !Reset && !Stall;
    assign w_ras_replace = Link & Return & !w_ras_empty;
    assign w_ras_push    = Link & !w_ras_replace;
    assign w_ras_pop     = Return & !Link & !w_ras_empty;
    assign w_ras_wr_idx  = w_ras_replace ? w_ras_top_idx : r_ras_ptr;
    assign w_unused_cfg  = 1'b0;

    always_ff @(posedge CLK) begin
        if (w_ras_active && (w_ras_push || w_ras_replace)) begin
            r_ras[w_ras_wr_idx] <= w_pc_plus4;
        end
    end

    // A push onto a full stack overwrites the oldest entry; the count just saturates.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (!Stall) begin
            if (w_ras_push) begin
                r_ras_ptr <= r_ras_ptr + PTR_W'(1);
                if (r_ras_cnt != (PTR_W+1)'(RAS_DEPTH)) begin
                    r_ras_cnt <= r_ras_cnt + (PTR_W+1)'(1);
                end
            end else if (w_ras_pop) begin
                r_ras_ptr <= w_ras_top_idx;
                r_ras_cnt <= r_ras_cnt - (PTR_W+1)'(1);
            end
        end
    end

    assign RasEmpty = w_ras_empty;
`else
    logic [31:0] w_unused_depth;

    assign w_unused_depth = 32'(RAS_DEPTH);
    assign w_unused_cfg   = ^{Link, w_unused_depth};
    assign w_ret_tgt      = RegTarget;
    assign RasEmpty       = 1'b1;
`endif

endmodule
